// File: rtl/recmes_llc_seq_pkg.sv
// Shared definitions for the receive-message LLC write sequencer:
// state encoding, buffer geometry and the data-length to word-count mapping.
package recmes_llc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRDATA,
        ST_WAITCPU,
        ST_WRCTRL,
        ST_DONE
    } state_t;

    // Number of 16-bit data registers in one receive buffer.
    localparam int RECMES_WORDS  = 4;
    // Largest meaningful data length code; codes above this still mean 8 bytes.
    localparam int RECMES_MAXDLC = 8;

    // Number of 16-bit words to write for a frame. A remote frame carries no
    // data, and an odd byte count rounds up to a whole word.
    function automatic logic [2:0] dlc2words(input logic rtr, input logic [3:0] dlc);
        logic [3:0] clipped;
        if (rtr) begin
            return 3'd0;
        end
        clipped = (dlc > 4'(RECMES_MAXDLC)) ? 4'(RECMES_MAXDLC) : dlc;
        return 3'((clipped + 4'd1) >> 1);
    endfunction

    // Word k of the received payload; byte 0 sits in the top byte of word 0.
    function automatic logic [15:0] select_word(input logic [63:0] data, input logic [1:0] k);
        logic [15:0] w;
        case (k)
            2'd0:    w = data[63:48];
            2'd1:    w = data[47:32];
            2'd2:    w = data[31:16];
            default: w = data[15:0];
        endcase
        return w;
    endfunction

    // One-hot write enable for data register k.
    function automatic logic [RECMES_WORDS-1:0] word_onehot(input logic [1:0] k);
        return RECMES_WORDS'(4'b0001 << k);
    endfunction

endpackage

// File: rtl/recmes_llc_seq.sv
// Receive-message LLC write sequencer for one CAN receive buffer.
// Copies an accepted frame's data words into the buffer, then issues one
// controller write to the control register and pulses the receive interrupt.
module recmes_llc_seq
    import recmes_llc_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rec_done,
    input  logic                    id_match,
    input  logic                    rtr_in,
    input  logic [3:0]              dlc_in,
    input  logic [63:0]             data_in,
    input  logic                    ric_cur,
    input  logic                    cpu_wr,
    output logic                    can,
    output logic                    ofc,
    output logic                    ric,
    output logic                    rtr,
    output logic [3:0]              dlc,
    output logic [RECMES_WORDS-1:0] data_we,
    output logic [15:0]             data_word,
    output logic                    busy,
    output logic                    rec_irq,
    output logic                    drop
);

    state_t      state;
    logic        match_lat;
    logic        rtr_lat;
    logic [3:0]  dlc_lat;
    logic [63:0] data_lat;
    logic [2:0]  words_lat;
    logic [1:0]  k;

    // Sequencer: every output is registered and set on the edge that enters
    // the state which owns it, so strobes line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            match_lat <= 1'b0;
            rtr_lat   <= 1'b0;
            dlc_lat   <= 4'd0;
            data_lat  <= 64'd0;
            words_lat <= 3'd0;
            k         <= 2'd0;
            can       <= 1'b0;
            ofc       <= 1'b0;
            ric       <= 1'b0;
            rtr       <= 1'b0;
            dlc       <= 4'd0;
            data_we   <= '0;
            data_word <= 16'd0;
            busy      <= 1'b0;
            rec_irq   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            can       <= 1'b0;
            ofc       <= 1'b0;
            ric       <= 1'b0;
            rtr       <= 1'b0;
            dlc       <= 4'd0;
            data_we   <= '0;
            data_word <= 16'd0;
            rec_irq   <= 1'b0;
            drop      <= rec_done && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (rec_done) begin
                        match_lat <= id_match;
                        rtr_lat   <= rtr_in;
                        dlc_lat   <= dlc_in;
                        data_lat  <= data_in;
                        busy      <= 1'b1;
                        state     <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    words_lat <= dlc2words(rtr_lat, dlc_lat);
                    if (!match_lat) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (dlc2words(rtr_lat, dlc_lat) == 3'd0) begin
                        state <= ST_WAITCPU;
                    end else begin
                        k         <= 2'd0;
                        data_we   <= word_onehot(2'd0);
                        data_word <= select_word(data_lat, 2'd0);
                        state     <= ST_WRDATA;
                    end
                end

                ST_WRDATA: begin
                    if ({1'b0, k} == words_lat - 3'd1) begin
                        state <= ST_WAITCPU;
                    end else begin
                        k         <= k + 2'd1;
                        data_we   <= word_onehot(k + 2'd1);
                        data_word <= select_word(data_lat, k + 2'd1);
                    end
                end

                ST_WAITCPU: begin
                    if (!cpu_wr) begin
                        can   <= 1'b1;
                        ric   <= 1'b1;
                        ofc   <= ric_cur;
                        rtr   <= rtr_lat;
                        dlc   <= dlc_lat;
                        state <= ST_WRCTRL;
                    end
                end

                ST_WRCTRL: begin
                    rec_irq <= 1'b1;
                    state   <= ST_DONE;
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/recmes_llc_seq.md
# recmes_llc_seq

Receive-message LLC write sequencer for one CAN receive buffer. It accepts a completed, filter-matched frame from the MAC and writes its data bytes into the buffer's data registers, one 16-bit word per cycle. It then issues the single-cycle `can` write to the receive-message control register, carrying `ric`, `ofc`, `rtr` and `dlc`. It sits directly upstream of the receive-message control register and the receive data registers, and gives the CPU write path priority over the controller.

## Interface
- Parameters: none; word count fixed at 4 (8 data bytes) via shared package constant.
- `clk` in 1 — system clock.
- `rst` in 1 — synchronous reset, active low.
- `rec_done` in 1 — MAC one-cycle pulse: frame received error-free.
- `id_match` in 1 — acceptance filter hit for this buffer; valid with `rec_done`.
- `rtr_in` in 1 — remote flag of received frame; valid with `rec_done`.
- `dlc_in` in 4 — data length code; valid with `rec_done`.
- `data_in` in 64 — received bytes; byte0 = [63:56]; valid with `rec_done`.
- `ric_cur` in 1 — current receive-indication bit of control register (regout[14]).
- `cpu_wr` in 1 — CPU is writing the control register this cycle.
- `can` out 1 — control-register write strobe (controller access).
- `ofc` out 1 — overflow indication to control register.
- `ric` out 1 — receive indication to control register.
- `rtr` out 1 — remote flag to control register.
- `dlc` out 4 — data length code to control register.
- `data_we` out 4 — one-hot data-register write enables, word 0..3.
- `data_word` out 16 — data word for `data_we`.
- `busy` out 1 — sequencer not in IDLE.
- `rec_irq` out 1 — one-cycle pulse after control write completes.
- `drop` out 1 — one-cycle pulse: `rec_done` arrived while busy, frame discarded.

## Operation
- States: IDLE, CHECK, WRDATA, WAITCPU, WRCTRL, DONE.
- IDLE: on `rec_done`=1, latch `rtr_in`, `dlc_in`, `data_in`, `id_match` → CHECK. Otherwise stay in IDLE.
- CHECK:
  - Unlatched filter miss → IDLE; no writes, no irq.
  - Otherwise compute n = 0 if rtr, else (min(dlc,8)+1)>>1 (3-bit result, range 0..4).
  - n=0 → WAITCPU; otherwise clear word index k=0 → WRDATA.
- WRDATA:
  - Drive `data_we`=1<<k and `data_word`=latched data[63-16k -: 16].
  - k==n-1 → WAITCPU; otherwise k+1.
  - Partial last word (odd dlc) is written whole; the unused low byte carries MAC data unchanged.
- WAITCPU: stay while `cpu_wr`=1 (CPU has priority); when `cpu_wr`=0, sample `ric_cur` into the overflow latch → WRCTRL.
- WRCTRL:
  - Assert `can`=1 for exactly one cycle, with `ric`=1, `ofc`=overflow latch, `rtr`=latched rtr, `dlc`=latched raw dlc (values 9..15 pass unchanged) → DONE.
  - If `cpu_wr` rises in this cycle, `can` is still issued. The register resolves the conflict (CPU wins); no retry.
- DONE: `rec_irq`=1 for one cycle → IDLE.
- `rec_done` in any state other than IDLE: ignored; `drop`=1 the next cycle; latches unchanged.
- Data is always written before control, so a CPU seeing `ric`=1 reads a complete message.

## Timing
- Reset (`rst`=0 at a clk edge):
  - State IDLE.
  - Outputs `can`, `ofc`, `ric`, `rtr`, `busy`, `rec_irq`, `drop` = 0; `dlc` = 0; `data_we` = 0; `data_word` = 0.
  - Latches and k cleared.
- Reset mid-sequence aborts the sequence and leaves partial data words written; control is never written.
- All outputs are registered.
- Latency from `rec_done` (cycle 0), with `cpu_wr`=0:
  - First `data_we` at cycle 2.
  - `can` at cycle 3+n.
  - `rec_irq` at cycle 4+n.
- Each `cpu_wr` cycle seen in WAITCPU adds one cycle.
- `busy` = 1 from cycle 1 until IDLE is re-entered.
- A `rec_done` in the same cycle as the `rec_irq` pulse is dropped; it is accepted from the following cycle.

## Structure
- Shared package holds:
  - state enum;
  - `RECMES_WORDS`=4, `RECMES_MAXDLC`=8;
  - function `dlc2words(rtr, dlc)` returning a 3-bit word count.
- No sub-module: the word-count and data-select logic is small enough to stay inline.

## Test plan
- Frame dlc=8, rtr=0, `ric_cur`=0, data=0x0011223344556677:
  - `data_we` 0001/0010/0100/1000 on cycles 2–5 with words 0x0011, 0x2233, 0x4455, 0x6677;
  - `can` on cycle 7 with ofc=0, ric=1, dlc=8;
  - `rec_irq` on cycle 8.
- dlc=3, `ric_cur`=1: two data words written; `can` on cycle 5 with ofc=1.
- rtr=1, dlc=5: no `data_we`; `can` on cycle 3 with rtr=1, dlc=5, ric=1.
- dlc=12: four words written; `dlc` output = 12.
- `id_match`=0: no `data_we`, no `can`, no irq; `busy` high for exactly 1 cycle.
- Boundary conditions:
  - `cpu_wr` held for 3 cycles during WAITCPU delays `can` by exactly 3 cycles.
  - A second `rec_done` while busy gives `drop`=1 and leaves the first frame's writes unchanged.
  - `rst`=0 during WRDATA returns all outputs to 0 the next cycle.
